// File: rtl/ysyx_22041752_clint.sv
// ysyx_22041752_clint
// Core-local interruptor for the RV64 core. Holds the machine timer (mtime),
// the timer compare register (mtimecmp) and the software-interrupt bit (msip).
// It is reached by the LSU through a single-outstanding request/response port.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_req_valid       LSU request valid
//   o_req_ready       request can be accepted (IDLE)
//   i_req_we          1 = write, 0 = read
//   i_req_addr        byte address, 8-byte aligned
//   i_req_wdata       write data
//   i_req_wstrb       byte write enables
//   o_resp_valid      response valid (RESP)
//   i_resp_ready      LSU accepts the response
//   o_resp_rdata      read data, 0 for writes, errors and while idle
//   o_resp_err        unmapped or misaligned address
//   o_mtip            level timer interrupt, feeds the CSR file's int_t_i
//   o_msip            software interrupt, msip bit 0
module ysyx_22041752_clint #(
    parameter logic [63:0] BASE = 64'h0000_0000_0200_0000,
    parameter int unsigned DIV  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [63:0] i_req_addr,
    input  logic [63:0] i_req_wdata,
    input  logic [7:0]  i_req_wstrb,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [63:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_mtip,
    output logic        o_msip
);

    typedef enum logic {
        S_IDLE,
        S_RESP
    } state_t;

    localparam logic [15:0] PRESC_MAX = 16'(DIV - 1);

    state_t      r_state;
    state_t      w_stateNext;

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_msip;
    logic        r_mtip;
    logic [15:0] r_prescaler;
    logic [63:0] r_respRdata;
    logic        r_respErr;

    logic [63:0] w_offset;
    logic        w_inWindow;
    logic        w_aligned;
    logic        w_selMsip;
    logic        w_selCmp;
    logic        w_selTime;
    logic        w_err;
    logic        w_accept;
    logic        w_respDone;
    logic        w_wrMsip;
    logic        w_wrCmp;
    logic        w_wrTime;
    logic        w_tick;
    logic [63:0] w_readData;

    function automatic logic [63:0] byteMerge(input logic [63:0] oldVal,
                                              input logic [63:0] newVal,
                                              input logic [7:0]  strb);
        logic [63:0] merged;
        for (int k = 0; k < 8; k++) begin
            merged[8*k +: 8] = strb[k] ? newVal[8*k +: 8] : oldVal[8*k +: 8];
        end
        return merged;
    endfunction

    // Offset subtraction makes the window check work for any BASE and
    // rejects addresses below BASE, which wrap to a huge offset.
    assign w_offset   = i_req_addr - BASE;
    assign w_inWindow = (w_offset[63:16] == 48'd0);
    assign w_aligned  = (i_req_addr[2:0] == 3'b000);
    assign w_selMsip  = w_inWindow && w_aligned && (w_offset[15:0] == 16'h0000);
    assign w_selCmp   = w_inWindow && w_aligned && (w_offset[15:0] == 16'h4000);
    assign w_selTime  = w_inWindow && w_aligned && (w_offset[15:0] == 16'hBFF8);
    assign w_err      = !(w_selMsip || w_selCmp || w_selTime);

    assign w_accept   = (r_state == S_IDLE) && i_req_valid;
    assign w_respDone = (r_state == S_RESP) && i_resp_ready;
    assign w_wrMsip   = w_accept && i_req_we && w_selMsip;
    assign w_wrCmp    = w_accept && i_req_we && w_selCmp;
    assign w_wrTime   = w_accept && i_req_we && w_selTime;
    assign w_tick     = (r_prescaler == PRESC_MAX);

    // Read data is taken from the registers before this cycle's update.
    always_comb begin
        w_readData = 64'd0;
        if (!i_req_we) begin
            if (w_selMsip) begin
                w_readData = {63'd0, r_msip};
            end else if (w_selCmp) begin
                w_readData = r_mtimecmp;
            end else if (w_selTime) begin
                w_readData = r_mtime;
            end
        end
    end

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        w_stateNext  = r_state;
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_stateNext = S_RESP;
                end
            end
            S_RESP: begin
                o_resp_valid = 1'b1;
                if (i_resp_ready) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Response payload: captured on accept, held through RESP, zero in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_respRdata <= 64'd0;
            r_respErr   <= 1'b0;
        end else if (w_accept) begin
            r_respRdata <= w_readData;
            r_respErr   <= w_err;
        end else if (w_respDone) begin
            r_respRdata <= 64'd0;
            r_respErr   <= 1'b0;
        end
    end

    // A software write to mtime beats a coincident tick and restarts the prescaler.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtime     <= 64'd0;
            r_prescaler <= 16'd0;
        end else if (w_wrTime) begin
            r_mtime     <= byteMerge(r_mtime, i_req_wdata, i_req_wstrb);
            r_prescaler <= 16'd0;
        end else if (w_tick) begin
            r_mtime     <= r_mtime + 64'd1;
            r_prescaler <= 16'd0;
        end else begin
            r_prescaler <= r_prescaler + 16'd1;
        end
    end

    // Compare and software-interrupt registers; mtip is a registered compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_msip     <= 1'b0;
            r_mtip     <= 1'b0;
        end else begin
            if (w_wrCmp) begin
                r_mtimecmp <= byteMerge(r_mtimecmp, i_req_wdata, i_req_wstrb);
            end
            if (w_wrMsip && i_req_wstrb[0]) begin
                r_msip <= i_req_wdata[0];
            end
            r_mtip <= (r_mtime >= r_mtimecmp);
        end
    end

    assign o_resp_rdata = r_respRdata;
    assign o_resp_err   = r_respErr;
    assign o_mtip       = r_mtip;
    assign o_msip       = r_msip;

endmodule

// File: tb/tb_ysyx_22041752_clint.sv
// tb_ysyx_22041752_clint
// Directed testbench for the CLINT. Two instances share one request bus:
// dut1 runs with DIV=1 and dut4 with DIV=4. Each phase checks the outputs of
// one instance only. Inputs are driven and outputs sampled on the falling edge.
// Step comments give k, the number of rising edges since the last reset release.
module tb_ysyx_22041752_clint;

    localparam logic [63:0] BASE  = 64'h0000_0000_0200_0000;
    localparam logic [63:0] MSIP  = BASE;
    localparam logic [63:0] CMP   = BASE + 64'h4000;
    localparam logic [63:0] MTIME = BASE + 64'hBFF8;
    localparam logic [63:0] ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        reset;
    logic        reqValid;
    logic        reqWe;
    logic [63:0] reqAddr;
    logic [63:0] reqWdata;
    logic [7:0]  reqWstrb;
    logic        respReady;

    logic        reqReady1, respValid1, respErr1, mtip1, msip1;
    logic [63:0] respRdata1;
    logic        reqReady4, respValid4, respErr4, mtip4, msip4;
    logic [63:0] respRdata4;

    logic [63:0] rd;
    logic        er;
    logic        mt;
    logic        ms;

    int assertCount = 0;
    int failCount   = 0;

    ysyx_22041752_clint #(.BASE(BASE), .DIV(1)) dut1 (
        .clk(clk), .reset(reset),
        .i_req_valid(reqValid), .o_req_ready(reqReady1), .i_req_we(reqWe),
        .i_req_addr(reqAddr), .i_req_wdata(reqWdata), .i_req_wstrb(reqWstrb),
        .o_resp_valid(respValid1), .i_resp_ready(respReady),
        .o_resp_rdata(respRdata1), .o_resp_err(respErr1),
        .o_mtip(mtip1), .o_msip(msip1)
    );

    ysyx_22041752_clint #(.BASE(BASE), .DIV(4)) dut4 (
        .clk(clk), .reset(reset),
        .i_req_valid(reqValid), .o_req_ready(reqReady4), .i_req_we(reqWe),
        .i_req_addr(reqAddr), .i_req_wdata(reqWdata), .i_req_wstrb(reqWstrb),
        .o_resp_valid(respValid4), .i_resp_ready(respReady),
        .o_resp_rdata(respRdata4), .o_resp_err(respErr4),
        .o_mtip(mtip4), .o_msip(msip4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One full transaction with resp_ready high: accept edge, then the
    // response sample, then the handshake edge. Called and returns on a
    // falling edge; takes two rising edges.
    task automatic applyStimulus(input bit useDiv4, input logic we,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [7:0] wstrb,
                                 output logic [63:0] rdata, output logic err,
                                 output logic mtipAtResp, output logic msipAtResp);
        reqValid  = 1'b1;
        reqWe     = we;
        reqAddr   = addr;
        reqWdata  = wdata;
        reqWstrb  = wstrb;
        respReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqValid   = 1'b0;
        rdata      = useDiv4 ? respRdata4 : respRdata1;
        err        = useDiv4 ? respErr4   : respErr1;
        mtipAtResp = useDiv4 ? mtip4      : mtip1;
        msipAtResp = useDiv4 ? msip4      : msip1;
        checkOutput("respValid", {63'd0, (useDiv4 ? respValid4 : respValid1)}, 64'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        reqValid  = 1'b0;
        reqWe     = 1'b0;
        reqAddr   = 64'd0;
        reqWdata  = 64'd0;
        reqWstrb  = 8'h00;
        respReady = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rstReqReady",  {63'd0, reqReady1},  64'd1);
        checkOutput("rstRespValid", {63'd0, respValid1}, 64'd0);
        checkOutput("rstRdata",     respRdata1,          64'd0);
        checkOutput("rstErr",       {63'd0, respErr1},   64'd0);
        checkOutput("rstMtip",      {63'd0, mtip1},      64'd0);
        checkOutput("rstMsip",      {63'd0, msip1},      64'd0);
        reset = 1'b0;                                         // k=0

        // DIV=1: free-running mtime
        applyStimulus(0, 0, MTIME, 64'd0, 8'h00, rd, er, mt, ms); // k=2
        checkOutput("mtimeFirst", rd, 64'd0);
        checkOutput("mtimeFirstErr", {63'd0, er}, 64'd0);
        repeat (100) @(negedge clk);                          // k=102
        checkOutput("mtipIdle", {63'd0, mtip1}, 64'd0);
        applyStimulus(0, 0, MTIME, 64'd0, 8'h00, rd, er, mt, ms); // k=104
        checkOutput("mtime102", rd, 64'd102);

        // Timer compare: mtime=10 after edge 105, i.e. mtime = k-95
        applyStimulus(0, 1, MTIME, 64'd10, 8'hFF, rd, er, mt, ms); // k=106
        checkOutput("wrRdataZero", rd, 64'd0);
        applyStimulus(0, 1, CMP, 64'd50, 8'hFF, rd, er, mt, ms);   // k=108
        repeat (37) @(negedge clk);                           // k=145, mtime=50
        checkOutput("mtipBefore", {63'd0, mtip1}, 64'd0);
        @(negedge clk);                                       // k=146
        checkOutput("mtipRise", {63'd0, mtip1}, 64'd1);
        repeat (3) @(negedge clk);                            // k=149
        checkOutput("mtipHold", {63'd0, mtip1}, 64'd1);
        applyStimulus(0, 1, CMP, ALL1, 8'hFF, rd, er, mt, ms);     // k=151
        checkOutput("mtipAtCmpWrEdge", {63'd0, mt}, 64'd1);
        checkOutput("mtipFall", {63'd0, mtip1}, 64'd0);

        // mtime wrap
        applyStimulus(0, 1, MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er, mt, ms); // k=153
        checkOutput("mtipBeforeWrap", {63'd0, mtip1}, 64'd0);
        applyStimulus(0, 0, MTIME, 64'd0, 8'h00, rd, er, mt, ms);  // k=155
        checkOutput("mtimeMax", rd, ALL1);
        checkOutput("mtipAtMax", {63'd0, mt}, 64'd1);
        checkOutput("mtipAfterWrap", {63'd0, mtip1}, 64'd0);
        applyStimulus(0, 0, MTIME, 64'd0, 8'h00, rd, er, mt, ms);  // k=157
        checkOutput("mtimeWrapped", rd, 64'd1);
        checkOutput("mtipLow", {63'd0, mt}, 64'd0);

        // Byte-merged write and decode errors that must not disturb registers
        applyStimulus(0, 1, CMP, 64'h1111_2222_3333_4444, 8'hFF, rd, er, mt, ms);
        applyStimulus(0, 1, CMP, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, rd, er, mt, ms);
        applyStimulus(0, 0, CMP, 64'd0, 8'h00, rd, er, mt, ms);
        checkOutput("cmpPartial", rd, 64'h1111_2222_CCCC_DDDD);
        applyStimulus(0, 1, BASE + 64'h1_4000, 64'd0, 8'hFF, rd, er, mt, ms);
        checkOutput("wrOutOfWindowErr", {63'd0, er}, 64'd1);
        applyStimulus(0, 1, BASE + 64'h4004, 64'd0, 8'hFF, rd, er, mt, ms);
        checkOutput("wrMisalignErr", {63'd0, er}, 64'd1);
        applyStimulus(0, 0, CMP, 64'd0, 8'h00, rd, er, mt, ms);
        checkOutput("cmpUntouched", rd, 64'h1111_2222_CCCC_DDDD);

        // msip
        checkOutput("msipInit", {63'd0, msip1}, 64'd0);
        applyStimulus(0, 1, MSIP, 64'd1, 8'h01, rd, er, mt, ms);
        checkOutput("msipRise", {63'd0, ms}, 64'd1);
        applyStimulus(0, 1, MSIP, 64'd0, 8'h00, rd, er, mt, ms);
        checkOutput("msipNoStrb", {63'd0, msip1}, 64'd1);
        applyStimulus(0, 1, MSIP, ALL1, 8'hFF, rd, er, mt, ms);
        applyStimulus(0, 0, MSIP, 64'd0, 8'h00, rd, er, mt, ms);
        checkOutput("msipReadback", rd, 64'd1);
        applyStimulus(0, 1, MSIP, 64'd0, 8'hFF, rd, er, mt, ms);
        checkOutput("msipClear", {63'd0, ms}, 64'd0);

        // Read errors
        applyStimulus(0, 0, BASE + 64'h0008, 64'd0, 8'h00, rd, er, mt, ms);
        checkOutput("errHoleFlag", {63'd0, er}, 64'd1);
        checkOutput("errHoleData", rd, 64'd0);
        applyStimulus(0, 0, BASE + 64'h4004, 64'd0, 8'h00, rd, er, mt, ms);
        checkOutput("errMisalign", {63'd0, er}, 64'd1);
        applyStimulus(0, 0, BASE - 64'd8, 64'd0, 8'h00, rd, er, mt, ms);
        checkOutput("errBelowBase", {63'd0, er}, 64'd1);

        // Response stall; a write offered during RESP must not be taken
        reqValid  = 1'b1;
        reqWe     = 1'b0;
        reqAddr   = CMP;
        respReady = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reqWe    = 1'b1;
        reqAddr  = MSIP;
        reqWdata = 64'd1;
        reqWstrb = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stallValid", {63'd0, respValid1}, 64'd1);
            checkOutput("stallReady", {63'd0, reqReady1},  64'd0);
            checkOutput("stallRdata", respRdata1, 64'h1111_2222_CCCC_DDDD);
            checkOutput("stallErr",   {63'd0, respErr1},   64'd0);
            @(negedge clk);
        end
        reqValid  = 1'b0;
        respReady = 1'b1;
        checkOutput("stallNoAccept", {63'd0, msip1}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("postValid", {63'd0, respValid1}, 64'd0);
        checkOutput("postReady", {63'd0, reqReady1},  64'd1);
        checkOutput("idleRdata", respRdata1, 64'd0);

        // DIV=4 phase: mtime = floor(k/4) until software writes it
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;                                         // k=0
        applyStimulus(1, 0, MTIME, 64'd0, 8'h00, rd, er, mt, ms); // k=2
        checkOutput("div4Start", rd, 64'd0);
        repeat (98) @(negedge clk);                           // k=100
        applyStimulus(1, 0, MTIME, 64'd0, 8'h00, rd, er, mt, ms); // k=102
        checkOutput("div4After100", rd, 64'd25);
        @(negedge clk);                                       // k=103, tick due at edge 104
        applyStimulus(1, 1, MTIME, 64'h1000, 8'hFF, rd, er, mt, ms); // k=105
        applyStimulus(1, 0, MTIME, 64'd0, 8'h00, rd, er, mt, ms);    // k=107
        checkOutput("div4WriteWins", rd, 64'h1000);
        applyStimulus(1, 0, MTIME, 64'd0, 8'h00, rd, er, mt, ms);    // k=109
        checkOutput("div4NoEarlyTick", rd, 64'h1000);
        applyStimulus(1, 0, MTIME, 64'd0, 8'h00, rd, er, mt, ms);    // k=111
        checkOutput("div4TickAfter4", rd, 64'h1001);
        @(negedge clk);                                       // k=112
        applyStimulus(1, 1, MTIME, 64'h2000, 8'hFF, rd, er, mt, ms); // k=114
        repeat (2) @(negedge clk);                            // k=116
        applyStimulus(1, 0, MTIME, 64'd0, 8'h00, rd, er, mt, ms);    // k=118
        checkOutput("div4PrescCleared", rd, 64'h2000);
        applyStimulus(1, 0, MTIME, 64'd0, 8'h00, rd, er, mt, ms);    // k=120
        checkOutput("div4TickAfterClear", rd, 64'h2001);

        // Reset while a response is pending
        reqValid  = 1'b1;
        reqWe     = 1'b0;
        reqAddr   = MTIME;
        respReady = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        checkOutput("preRstValid", {63'd0, respValid4}, 64'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstRespValid4", {63'd0, respValid4}, 64'd0);
        checkOutput("rstReqReady4",  {63'd0, reqReady4},  64'd1);
        checkOutput("rstRdata4",     respRdata4,          64'd0);
        checkOutput("rstMtip4",      {63'd0, mtip4},      64'd0);
        reset = 1'b0;                                         // k=0
        applyStimulus(1, 0, MTIME, 64'd0, 8'h00, rd, er, mt, ms);
        checkOutput("rstMtime4", rd, 64'd0);
        applyStimulus(1, 0, CMP, 64'd0, 8'h00, rd, er, mt, ms);
        checkOutput("rstCmp4", rd, ALL1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ysyx_22041752_clint.md
Name: ysyx_22041752_clint

Overview:
- Core-local interruptor (CLINT) for the RV64 core, sitting directly upstream of the CSR file.
- Holds the memory-mapped machine timer (mtime), the timer compare register (mtimecmp) and the software-interrupt register (msip).
- Drives the level-sensitive timer interrupt request into the CSR file's timer-interrupt input (int_t_i), which becomes mip.MTIP there.
- Accessed by the LSU through a single-outstanding valid/ready request/response port.

Parameters:
- BASE, 64'h0000_0000_0200_0000: base address of the 64 KiB CLINT window.
- DIV, 1: mtime increments once every DIV clk cycles. Legal range is 1..65535.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  LSU request valid
- req_ready  out  1  CLINT can accept a request
- req_we  in  1  1=write, 0=read
- req_addr  in  64  byte address, must be 8-byte aligned
- req_wdata  in  64  write data
- req_wstrb  in  8  byte write enables
- resp_valid  out  1  response valid
- resp_ready  in  1  LSU accepts response
- resp_rdata  out  64  read data (0 for writes and errors)
- resp_err  out  1  address outside the register map, or misaligned
- mtip  out  1  timer interrupt request, connected to the CSR file's int_t_i
- msip  out  1  software interrupt request (msip[0])

Behaviour:
- Register map (offset from BASE):
  - 0x0000 msip: bit0 is writable; bits 63:1 read as 0.
  - 0x4000 mtimecmp: 64 bits, read/write.
  - 0xBFF8 mtime: 64 bits, read/write.
  - Any other offset, any address outside [BASE, BASE+0xFFFF], or addr[2:0]!=0 gives resp_err=1, and no register changes.
- Reset values: mtime=0; mtimecmp=64'hFFFF_FFFF_FFFF_FFFF; msip=0; mtip=0; prescaler=0; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0.
- Handshake FSM, two states:
  - IDLE: req_ready=1, resp_valid=0. On req_valid, the request is accepted at the end of that cycle (cycle t); go to RESP.
  - RESP: req_ready=0, resp_valid=1, and resp_rdata/resp_err are held stable. Leave to IDLE when resp_ready=1. There is no back-to-back accept in the same cycle as a response handshake.
  - Latency: accept at cycle t, response visible at t+1; minimum two cycles per access.
  - Reads return the register value as of cycle t, before any update in cycle t.
- Writes:
  - Take effect at the clk edge ending cycle t.
  - Byte-merged: new[8k+7:8k] = wstrb[k] ? wdata[8k+7:8k] : old.
  - msip updates only when wstrb[0]=1.
- Prescaler and mtime:
  - The prescaler counts 0..DIV-1. When it equals DIV-1 it wraps to 0 and mtime increments by 1.
  - With DIV=1, mtime increments every cycle.
  - mtime wraps from 2^64-1 to 0 with no sticky flag.
- Simultaneous mtime events: a software write to mtime in the same cycle as a tick means the write wins (the tick is dropped). Any mtime write also clears the prescaler to 0.
- Timer compare:
  - Registered: mtip at edge t+1 = (mtime_q >= mtimecmp_q) evaluated in cycle t, unsigned 64-bit.
  - mtip stays high while the condition holds.
  - mtip clears one cycle after software raises mtimecmp above mtime.
- msip output is msip register bit0 directly, with no extra latency.
- Reset mid-transaction: the response is dropped, the FSM returns to IDLE, and all registers go to their reset values.
- resp_rdata is 0 in IDLE.

Test Plan:
- Reset release with DIV=1, no accesses:
  - mtime reads 0 on the first access after reset.
  - After 100 idle cycles a read of 0x0200_BFF8 returns a value within [100,104].
  - mtip=0 throughout.
- Write mtimecmp=64'd50 (wstrb=8'hFF) at mtime≈10:
  - mtip rises exactly one cycle after mtime reaches 50 and stays 1.
  - Then write mtimecmp=64'hFFFF_FFFF_FFFF_FFFF: mtip falls one cycle after the write edge.
- Write mtime=64'hFFFF_FFFF_FFFF_FFFE, then read twice:
  - The value wraps through 64'hFFFF_FFFF_FFFF_FFFF to small values (0,1,...).
  - With mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, mtip pulses high exactly while mtime=2^64-1, then falls one cycle after the wrap.
- Partial write to mtimecmp=64'h1111_2222_3333_4444 with wdata=64'hAAAA_BBBB_CCCC_DDDD, wstrb=8'h0F:
  - Readback is 64'h1111_2222_CCCC_DDDD.
  - A write to msip with wstrb=8'h00 leaves msip unchanged.
- Handshake and error:
  - Read of BASE+0x0008 gives resp_err=1 and rdata=0.
  - Read of BASE+0x4004 (misaligned) gives resp_err=1.
  - Holding resp_ready=0 for 5 cycles keeps resp_valid, rdata and err stable and req_ready=0.
  - A write to msip of 1 raises the msip output on the cycle after acceptance.
- DIV=4:
  - mtime advances by exactly 25 over 100 cycles.
  - An mtime write coincident with a tick leaves mtime equal to the written value, and the next increment occurs 4 cycles later.
  - Asserting reset while in RESP gives resp_valid=0 and req_ready=1 on the next cycle.
